// File: rtl/sha256_periph_pkg.sv
// rtl/sha256_periph_pkg.sv - register map, bit indices, responses and FSM states
package sha256_periph_pkg;

    localparam logic [31:0] DEF_BASE_ADDR  = 32'h3000_0000;
    localparam int          DEF_MSG_WORDS  = 16;
    localparam int          DEF_HASH_WORDS = 8;

    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_STATUS = 12'h004;
    localparam logic [11:0] OFF_MSG    = 12'h100;
    localparam logic [11:0] OFF_HASH   = 12'h200;

    localparam int CTRL_START   = 0;
    localparam int CTRL_INIT    = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int STATUS_DONE  = 0;
    localparam int STATUS_BUSY  = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

endpackage

// File: rtl/axi4_sha256_periph_if.sv
// rtl/axi4_sha256_periph_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi4_sha256_periph_if;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi4l_slave_if.sv
// rtl/axi4l_slave_if.sv - AXI4-Lite handshakes reduced to single-cycle wr_en/rd_en strobes
module axi4l_slave_if
    import sha256_periph_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    axi4_sha256_periph_if.slave  s_axi,
    output logic                 wr_en,
    output logic [31:0]          wr_addr,
    output logic [31:0]          wr_data,
    output logic [3:0]           wr_strb,
    input  logic                 wr_err,
    output logic                 rd_en,
    output logic [31:0]          rd_addr,
    input  logic [31:0]          rd_data,
    input  logic                 rd_err
);

    logic        rdy_q, rdy_d;
    logic        aw_held_q, aw_held_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic        w_held_q, w_held_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    // Readies stay low through reset and the first cycle after it so every output reads 0 in reset.
    assign s_axi.awready = rdy_q && !aw_held_q && !bvalid_q;
    assign s_axi.wready  = rdy_q && !w_held_q && !bvalid_q;
    assign s_axi.arready = rdy_q && !rvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign wr_en   = aw_held_q && w_held_q && !bvalid_q;
    assign wr_addr = awaddr_q;
    assign wr_data = wdata_q;
    assign wr_strb = wstrb_q;
    assign rd_en   = s_axi.arvalid && s_axi.arready;
    assign rd_addr = s_axi.araddr;

    always_comb begin
        rdy_d     = 1'b1;
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (s_axi.awvalid && s_axi.awready) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi.awaddr;
        end
        if (s_axi.wvalid && s_axi.wready) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.wdata;
            wstrb_d  = s_axi.wstrb;
        end
        if (wr_en) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_q && s_axi.bready) begin
            bvalid_d = 1'b0;
        end

        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_err ? 32'h0 : rd_data;
            rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_q     <= 1'b0;
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            rdy_q     <= rdy_d;
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

endmodule

// File: rtl/axi4_sha256_periph.sv
// rtl/axi4_sha256_periph.sv - SHA-256 core register file, launch/capture FSM and AXI4-Lite front end
module axi4_sha256_periph
    import sha256_periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          MSG_WORDS  = DEF_MSG_WORDS,
    parameter int          HASH_WORDS = DEF_HASH_WORDS
) (
    input  logic                     clk,
    input  logic                     resetn,
    axi4_sha256_periph_if.slave      s_axi,
    output logic [MSG_WORDS*32-1:0]  core_message,
    output logic                     core_start,
    output logic                     core_init,
    input  logic                     core_ready,
    input  logic [HASH_WORDS*32-1:0] core_hash,
    output logic                     irq
);

    logic        wr_en, wr_err, rd_en, rd_err;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [3:0]  wr_strb;
    logic [11:0] wr_off, rd_off;
    logic        busy, start_req, msg_hit, rd_hit;

    state_e      state_q, state_d;
    logic        init_q, init_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        core_start_q, core_start_d;
    logic [31:0] msg_q  [MSG_WORDS];
    logic [31:0] msg_d  [MSG_WORDS];
    logic [31:0] hash_q [HASH_WORDS];
    logic [31:0] hash_d [HASH_WORDS];

    axi4l_slave_if u_slv (
        .clk     (clk),
        .resetn  (resetn),
        .s_axi   (s_axi),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .wr_err  (wr_err),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_err  (rd_err)
    );

    assign busy       = (state_q != ST_IDLE);
    assign wr_off     = wr_addr[11:0];
    assign rd_off     = rd_addr[11:0];
    assign core_start = core_start_q;
    assign core_init  = init_q;
    assign irq        = done_q & irq_en_q;

    always_comb begin
        core_message = '0;
        for (int i = 0; i < MSG_WORDS; i++) begin
            core_message[(MSG_WORDS-1-i)*32 +: 32] = msg_q[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        init_d       = init_q;
        irq_en_d     = irq_en_q;
        done_d       = done_q;
        core_start_d = 1'b0;
        msg_d        = msg_q;
        hash_d       = hash_q;
        wr_err       = 1'b0;
        start_req    = 1'b0;
        msg_hit      = 1'b0;

        if (wr_en) begin
            if (wr_addr[31:12] != BASE_ADDR[31:12] || wr_addr[1:0] != 2'b00) begin
                wr_err = 1'b1;
            end else if (wr_off == OFF_CTRL) begin
                if (busy) begin
                    wr_err = 1'b1;
                end else if (wr_strb[0]) begin
                    start_req = wr_data[CTRL_START];
                    init_d    = wr_data[CTRL_INIT];
                    irq_en_d  = wr_data[CTRL_IRQ_EN];
                end
            end else if (wr_off == OFF_STATUS) begin
                if (wr_strb[0] && wr_data[STATUS_DONE]) begin
                    done_d = 1'b0;
                end
            end else if (wr_off[11:8] == OFF_MSG[11:8]) begin
                for (int i = 0; i < MSG_WORDS; i++) begin
                    if (wr_off[7:2] == i[5:0]) begin
                        msg_hit = 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (!busy && wr_strb[b]) begin
                                msg_d[i][8*b +: 8] = wr_data[8*b +: 8];
                            end
                        end
                    end
                end
                wr_err = !msg_hit || busy;
            end else begin
                wr_err = 1'b1;
            end
        end

        // FSM runs after the register decode so a CAPTURE in the same cycle as a DONE W1C keeps DONE set.
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    core_start_d = 1'b1;
                    done_d       = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!core_start_q && core_ready) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                for (int i = 0; i < HASH_WORDS; i++) begin
                    hash_d[i] = core_hash[(HASH_WORDS-1-i)*32 +: 32];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        rd_hit  = 1'b0;
        if (rd_en) begin
            if (rd_addr[31:12] != BASE_ADDR[31:12] || rd_addr[1:0] != 2'b00) begin
                rd_err = 1'b1;
            end else if (rd_off == OFF_CTRL) begin
                rd_data[CTRL_IRQ_EN] = irq_en_q;
                rd_data[CTRL_INIT]   = init_q;
            end else if (rd_off == OFF_STATUS) begin
                rd_data[STATUS_DONE] = done_q;
                rd_data[STATUS_BUSY] = busy;
            end else if (rd_off[11:8] == OFF_MSG[11:8]) begin
                for (int i = 0; i < MSG_WORDS; i++) begin
                    if (rd_off[7:2] == i[5:0]) begin
                        rd_hit  = 1'b1;
                        rd_data = msg_q[i];
                    end
                end
                rd_err = !rd_hit;
            end else if (rd_off[11:8] == OFF_HASH[11:8]) begin
                for (int i = 0; i < HASH_WORDS; i++) begin
                    if (rd_off[7:2] == i[5:0]) begin
                        rd_hit  = 1'b1;
                        rd_data = hash_q[i];
                    end
                end
                rd_err = !rd_hit;
            end else begin
                rd_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            init_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            core_start_q <= 1'b0;
            for (int i = 0; i < MSG_WORDS; i++)  msg_q[i]  <= '0;
            for (int i = 0; i < HASH_WORDS; i++) hash_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            init_q       <= init_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            core_start_q <= core_start_d;
            msg_q        <= msg_d;
            hash_q       <= hash_d;
        end
    end

endmodule

// File: tb/tb_axi4_sha256_periph.sv
// tb/tb_axi4_sha256_periph.sv - scoreboard bench for axi4_sha256_periph with a behavioural core
module tb_axi4_sha256_periph;
    import sha256_periph_pkg::*;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          LIMIT = 200;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [511:0] core_message;
    logic         core_start, core_init, irq;
    logic         core_ready = 1'b0;
    logic [255:0] core_hash = '0;

    axi4_sha256_periph_if bus ();

    always #5 clk = ~clk;

    axi4_sha256_periph dut (
        .clk          (clk),
        .resetn       (resetn),
        .s_axi        (bus),
        .core_message (core_message),
        .core_start   (core_start),
        .core_init    (core_init),
        .core_ready   (core_ready),
        .core_hash    (core_hash),
        .irq          (irq)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        b_q[$];
    exp_t        r_q[$];
    int          total = 0;
    int          bad   = 0;
    int          starts = 0;
    int          core_lat = 3;
    logic        init_seen = 1'b0;
    logic [31:0] msg0_seen = '0;
    logic [31:0] msg15_seen = '0;
    logic [31:0] dig_abc [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                 32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out after %0d cycles", name, LIMIT);
    endtask

    // Behavioural core: IV start returns the "abc" digest, chained start returns c0de000i.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && core_start) begin
                starts++;
                init_seen  = core_init;
                msg0_seen  = core_message[511:480];
                msg15_seen = core_message[31:0];
                repeat (core_lat) @(posedge clk);
                #1;
                for (int i = 0; i < 8; i++)
                    core_hash[(7-i)*32 +: 32] = init_seen ? dig_abc[i] : (32'hc0de_0000 + 32'(i));
                core_ready = 1'b1;
                @(posedge clk);
                #1 core_ready = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && bus.bvalid && bus.bready) begin
                if (b_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_b: got bresp %0d want no response", bus.bresp);
                end else begin
                    e = b_q.pop_front();
                    check($sformatf("bresp@%h", e.addr), 64'(bus.bresp), 64'(e.resp));
                end
            end
            if (resetn && bus.rvalid && bus.rready) begin
                if (r_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_r: got rdata %h want no response", bus.rdata);
                end else begin
                    e = r_q.pop_front();
                    check($sformatf("rdata@%h", e.addr), {30'h0, bus.rresp, bus.rdata}, {30'h0, e.resp, e.data});
                end
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] resp, input int aw_dly, input int w_dly, input int b_dly);
        exp_t e;
        int   k;
        e.addr = addr; e.data = data; e.resp = resp;
        b_q.push_back(e);
        @(posedge clk); #1;
        fork
            begin
                int  ka;
                logic hs;
                ka = 0;
                repeat (aw_dly) begin @(posedge clk); #1; end
                bus.awvalid = 1'b1; bus.awaddr = addr;
                do begin hs = bus.awready; @(posedge clk); #1; ka++; end while (!hs && ka < LIMIT);
                bus.awvalid = 1'b0;
                if (!hs) timeout("aw_handshake");
            end
            begin
                int  kw;
                logic hs;
                kw = 0;
                repeat (w_dly) begin @(posedge clk); #1; end
                bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb;
                do begin hs = bus.wready; @(posedge clk); #1; kw++; end while (!hs && kw < LIMIT);
                bus.wvalid = 1'b0;
                if (!hs) timeout("w_handshake");
            end
        join
        k = 0;
        while (!bus.bvalid && k < LIMIT) begin @(posedge clk); #1; k++; end
        if (!bus.bvalid) begin
            timeout("bvalid");
            void'(b_q.pop_back());
        end else begin
            repeat (b_dly) begin @(posedge clk); #1; end
            bus.bready = 1'b1;
            @(posedge clk); #1;
            bus.bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                            input int pre_dly, input int r_dly);
        exp_t e;
        int   k;
        logic hs;
        e.addr = addr; e.data = data; e.resp = resp;
        r_q.push_back(e);
        @(posedge clk); #1;
        repeat (pre_dly) begin @(posedge clk); #1; end
        bus.arvalid = 1'b1; bus.araddr = addr;
        k = 0;
        do begin hs = bus.arready; @(posedge clk); #1; k++; end while (!hs && k < LIMIT);
        bus.arvalid = 1'b0;
        if (!hs) timeout("ar_handshake");
        k = 0;
        while (!bus.rvalid && k < LIMIT) begin @(posedge clk); #1; k++; end
        if (!bus.rvalid) begin
            timeout("rvalid");
            void'(r_q.pop_back());
        end else begin
            repeat (r_dly) begin @(posedge clk); #1; end
            bus.rready = 1'b1;
            @(posedge clk); #1;
            bus.rready = 1'b0;
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp,
                    bus.rresp, bus.rdata, core_start, core_init, irq, |core_message});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic hs;
        int   k;
        bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;

        repeat (3) @(posedge clk);
        #1 check("reset_outputs", out_vec(), 64'h0);
        resetn = 1'b1;
        axi_read(BASE + 32'h000, 32'h0, RESP_OKAY, 0, 0);
        axi_read(BASE + 32'h004, 32'h0, RESP_OKAY, 0, 0);
        axi_read(BASE + 32'h200, 32'h0, RESP_OKAY, 0, 0);

        // First block from IV: "abc" padded.
        axi_write(BASE + 32'h100, 32'h61626380, 4'hf, RESP_OKAY, 0, 0, 0);
        axi_write(BASE + 32'h13c, 32'h00000018, 4'hf, RESP_OKAY, 0, 0, 0);
        axi_write(BASE + 32'h000, 32'h3, 4'hf, RESP_OKAY, 0, 0, 0);
        repeat (15) @(posedge clk);
        #1;
        check("starts_1", 64'(starts), 64'd1);
        check("init_seen_1", 64'(init_seen), 64'd1);
        check("msg0_seen", 64'(msg0_seen), 64'h61626380);
        check("msg15_seen", 64'(msg15_seen), 64'h18);
        check("irq_disabled", 64'(irq), 64'd0);
        axi_read(BASE + 32'h004, 32'h1, RESP_OKAY, 0, 0);
        axi_read(BASE + 32'h200, 32'hba7816bf, RESP_OKAY, 0, 0);
        axi_read(BASE + 32'h21c, 32'hf20015ad, RESP_OKAY, 0, 0);
        axi_read(BASE + 32'h000, 32'h2, RESP_OKAY, 0, 0);

        // Chained block with interrupt enabled, then W1C.
        axi_write(BASE + 32'h000, 32'h5, 4'hf, RESP_OKAY, 0, 0, 0);
        repeat (15) @(posedge clk);
        #1;
        check("starts_2", 64'(starts), 64'd2);
        check("init_seen_2", 64'(init_seen), 64'd0);
        check("irq_on_done", 64'(irq), 64'd1);
        axi_read(BASE + 32'h200, 32'hc0de0000, RESP_OKAY, 0, 0);
        axi_read(BASE + 32'h21c, 32'hc0de0007, RESP_OKAY, 0, 0);
        axi_read(BASE + 32'h000, 32'h4, RESP_OKAY, 0, 0);
        axi_write(BASE + 32'h004, 32'h1, 4'hf, RESP_OKAY, 0, 0, 0);
        #1 check("irq_after_w1c", 64'(irq), 64'd0);
        axi_read(BASE + 32'h004, 32'h0, RESP_OKAY, 0, 0);

        // Byte strobes, then busy protection.
        axi_write(BASE + 32'h10c, 32'h12345678, 4'hf, RESP_OKAY, 0, 0, 0);
        axi_write(BASE + 32'h10c, 32'hAABBCCDD, 4'b0101, RESP_OKAY, 0, 0, 0);
        axi_read(BASE + 32'h10c, 32'h12BB56DD, RESP_OKAY, 0, 0);
        core_lat = 30;
        axi_write(BASE + 32'h000, 32'h1, 4'hf, RESP_OKAY, 0, 0, 0);
        axi_read(BASE + 32'h004, 32'h2, RESP_OKAY, 0, 0);
        axi_write(BASE + 32'h10c, 32'hdeadbeef, 4'hf, RESP_SLVERR, 0, 0, 0);
        axi_write(BASE + 32'h000, 32'h3, 4'hf, RESP_SLVERR, 0, 0, 0);
        axi_read(BASE + 32'h000, 32'h0, RESP_OKAY, 0, 0);
        repeat (45) @(posedge clk);
        #1 check("starts_busy", 64'(starts), 64'd3);
        axi_read(BASE + 32'h10c, 32'h12BB56DD, RESP_OKAY, 0, 0);
        axi_read(BASE + 32'h004, 32'h1, RESP_OKAY, 0, 0);

        // Handshake ordering and backpressure.
        axi_write(BASE + 32'h104, 32'h0badf00d, 4'hf, RESP_OKAY, 3, 0, 5);
        axi_read(BASE + 32'h104, 32'h0badf00d, RESP_OKAY, 0, 4);
        axi_write(BASE + 32'h108, 32'hcafef00d, 4'hf, RESP_OKAY, 0, 2, 0);
        axi_read(BASE + 32'h108, 32'hcafef00d, RESP_OKAY, 0, 0);
        fork
            axi_write(BASE + 32'h104, 32'h55667788, 4'hf, RESP_OKAY, 0, 0, 0);
            axi_read(BASE + 32'h104, 32'h0badf00d, RESP_OKAY, 1, 0);
        join
        axi_read(BASE + 32'h104, 32'h55667788, RESP_OKAY, 0, 0);

        // Error responses.
        axi_read(BASE + 32'h300, 32'h0, RESP_SLVERR, 0, 0);
        axi_write(BASE + 32'h200, 32'h1, 4'hf, RESP_SLVERR, 0, 0, 0);
        axi_write(BASE + 32'hffc, 32'h1, 4'hf, RESP_SLVERR, 0, 0, 0);
        axi_read(32'h4000_0000, 32'h0, RESP_SLVERR, 0, 0);
        axi_read(BASE + 32'h140, 32'h0, RESP_SLVERR, 0, 0);
        axi_read(BASE + 32'h200, 32'hc0de0000, RESP_OKAY, 0, 0);

        // Reset mid-RUN with a read response still pending.
        core_lat = 25;
        axi_write(BASE + 32'h000, 32'h1, 4'hf, RESP_OKAY, 0, 0, 0);
        bus.arvalid = 1'b1; bus.araddr = BASE + 32'h100;
        k = 0;
        do begin hs = bus.arready; @(posedge clk); #1; k++; end while (!hs && k < LIMIT);
        bus.arvalid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("rvalid_pending", 64'(bus.rvalid), 64'd1);
        resetn = 1'b0;
        #1 check("midrun_reset_outputs", out_vec(), 64'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        axi_read(BASE + 32'h004, 32'h0, RESP_OKAY, 0, 0);
        axi_read(BASE + 32'h200, 32'h0, RESP_OKAY, 0, 0);
        axi_read(BASE + 32'h100, 32'h0, RESP_OKAY, 0, 0);
        repeat (40) @(posedge clk);
        #1 check("starts_after_abort", 64'(starts), 64'd4);
        axi_read(BASE + 32'h004, 32'h0, RESP_OKAY, 0, 0);
        axi_read(BASE + 32'h200, 32'h0, RESP_OKAY, 0, 0);
        axi_read(BASE + 32'h000, 32'h0, RESP_OKAY, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        if (b_q.size() != 0 || r_q.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending want 0/0", b_q.size(), r_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
